// File: rtl/fpa_share_arb.sv
// Round-robin scheduler time-sharing one combinational FP adder between two requesters.
// Optional feature macro: FPA_ARB_ZERO_BYPASS_EN (zero-operand short-circuit).
module fpa_share_arb #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_b0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b1,
    output logic [1:0]  req_ready,
    output logic [1:0]  resp_valid,
    output logic [31:0] resp_sum,
    output logic        resp_of,
    output logic        busy,
    output logic [31:0] fpa_a,
    output logic [31:0] fpa_b,
    input  logic [31:0] fpa_sum,
    input  logic        fpa_of
);

    localparam logic [3:0] SettleCnt = 4'(SETTLE);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        prio_q, prio_d;
    logic        owner_q, owner_d;
    logic [31:0] fpa_a_q, fpa_a_d;
    logic [31:0] fpa_b_q, fpa_b_d;
    logic [31:0] sum_q, sum_d;
    logic        of_q, of_d;

    logic [1:0]  grant;
    logic        sel;
    logic [31:0] acc_a, acc_b;
`ifdef FPA_ARB_ZERO_BYPASS_EN
    logic        a_zero, b_zero;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        fpa_a_d = fpa_a_q;
        fpa_b_d = fpa_b_q;
        sum_d   = sum_q;
        of_d    = of_q;
        grant   = 2'b00;
        sel     = 1'b0;
        acc_a   = '0;
        acc_b   = '0;
`ifdef FPA_ARB_ZERO_BYPASS_EN
        a_zero  = 1'b0;
        b_zero  = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_valid != 2'b00) begin
                    // Contention goes to prio; otherwise the lone requester wins.
                    sel     = (req_valid == 2'b11) ? prio_q : req_valid[1];
                    grant   = sel ? 2'b10 : 2'b01;
                    acc_a   = sel ? req_a1 : req_a0;
                    acc_b   = sel ? req_b1 : req_b0;
                    fpa_a_d = acc_a;
                    fpa_b_d = acc_b;
                    owner_d = sel;
                    prio_d  = ~sel;
                    cnt_d   = SettleCnt;
                    state_d = StExec;
`ifdef FPA_ARB_ZERO_BYPASS_EN
                    a_zero = (acc_a[30:0] == 31'd0);
                    b_zero = (acc_b[30:0] == 31'd0);
                    if (a_zero || b_zero) begin
                        state_d = StDone;
                        cnt_d   = 4'd0;
                        of_d    = 1'b0;
                        if (a_zero && b_zero) begin
                            sum_d = {acc_a[31] & acc_b[31], 31'd0};
                        end else if (a_zero) begin
                            sum_d = acc_b;
                        end else begin
                            sum_d = acc_a;
                        end
                    end
`endif
                end
            end
            StExec: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    sum_d   = fpa_sum;
                    of_d    = fpa_of;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            fpa_a_q <= '0;
            fpa_b_q <= '0;
            sum_q   <= '0;
            of_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            fpa_a_q <= fpa_a_d;
            fpa_b_q <= fpa_b_d;
            sum_q   <= sum_d;
            of_q    <= of_d;
        end
    end

    // Handshake pulses are suppressed while reset is held so an aborted cycle grants nothing.
    assign req_ready  = rst ? 2'b00 : grant;
    assign resp_valid = (rst || state_q != StDone) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
    assign busy       = (state_q != StIdle);
    assign resp_sum   = sum_q;
    assign resp_of    = of_q;
    assign fpa_a      = fpa_a_q;
    assign fpa_b      = fpa_b_q;

endmodule
